// File: rtl/bus_selftest_master_if.sv
// -----------------------------------------------------------------------------
// bus_selftest_master_if
//   Word-wide CPU-style bus between the self-test master and the bus decoder.
//   The decoder routes addr_bus[31:28] = 0 to RAM, E to the display GPIO and
//   F to the LED GPIO. Reads have a latency of one clock: data for the address
//   presented in one cycle appears on Cpu_data4bus in the following cycle.
//
//   Signals
//     addr_bus      master -> slave   byte address of the word access
//     Cpu_data2bus  master -> slave   write data
//     mem_w         master -> slave   write strobe (one word per cycle)
//     Cpu_data4bus  slave  -> master  read data
// -----------------------------------------------------------------------------
interface bus_selftest_master_if;
  logic [31:0] addr_bus;
  logic [31:0] Cpu_data2bus;
  logic        mem_w;
  logic [31:0] Cpu_data4bus;

  modport master (
    output addr_bus,
    output Cpu_data2bus,
    output mem_w,
    input  Cpu_data4bus
  );

  modport slave (
    input  addr_bus,
    input  Cpu_data2bus,
    input  mem_w,
    output Cpu_data4bus
  );
endinterface : bus_selftest_master_if

// File: rtl/bus_selftest_master.sv
// -----------------------------------------------------------------------------
// bus_selftest_master
//   Bus-initiator RAM self test. On start it writes a pattern to N_WORDS RAM
//   words, reads every word back and compares it, then reports the result to
//   the display GPIO ({err_count, first_err}) and the LED GPIO (all on for a
//   clean run, low nibble only otherwise), and finally pulses done.
//
//   Pattern for word i:  {i[15:0], ~i[15:0]} ^ SEED
//
//   Cycle budget for one run, counting the first write cycle as 0:
//     writes 0..N-1, read/compare pairs N..3N-1, display report 3N,
//     LED report 3N+1, done pulse 3N+2.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous, active-low reset
//     start      begin a run; honoured only in IDLE or DONE
//     bus        master side of the word bus (address, write data, strobe,
//                read data)
//     busy       high while a run is in progress (not in IDLE or DONE)
//     done       one-cycle pulse marking the end of a run
//     pass       last completed run had no mismatch; cleared by a new start
//     err_count  mismatch count of the last run, saturating at 16'hFFFF
//
//   Every output is decoded from registers only; the read data and start
//   input reach nothing but next-state logic.
// -----------------------------------------------------------------------------
module bus_selftest_master #(
  parameter int          N_WORDS = 16,            // 1..1024
  parameter logic [31:0] SEED    = 32'h1234_5678
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  bus_selftest_master_if.master        bus,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [15:0]                  err_count
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_CMP,
    REP_SEG,
    REP_LED,
    DONE
  } state_t;

  localparam logic [9:0]  LAST_IDX = 10'(N_WORDS - 1);
  localparam logic [15:0] NO_ERR   = 16'hFFFF;   // first_err value before any mismatch
  localparam logic [31:0] SEG_ADDR = 32'hE000_0000;
  localparam logic [31:0] LED_ADDR = 32'hF000_0000;
  localparam logic [7:0]  LED_OK   = 8'hFF;
  localparam logic [7:0]  LED_BAD  = 8'h0F;

  state_t      state, state_nxt;
  logic [9:0]  idx, idx_nxt;
  logic [15:0] err_count_nxt;
  logic [15:0] first_err, first_err_nxt;
  logic        pass_nxt;

  // Datapath helpers, all functions of registered state.
  logic [15:0] idx16;
  logic [31:0] pat;
  logic [31:0] word_addr;
  logic        last_idx;
  logic        mismatch;
  logic [7:0]  led;

  // Output decode targets.
  logic        mem_w_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic        busy_d;
  logic        done_d;

  assign idx16     = {6'b0, idx};
  assign pat       = {idx16, ~idx16} ^ SEED;
  // Only ten index bits feed the address, so N_WORDS = 1024 wraps cleanly
  // without ever touching addr_bus[31:12].
  assign word_addr = {20'h0, idx, 2'b00};
  assign last_idx  = (idx == LAST_IDX);
  assign mismatch  = (bus.Cpu_data4bus != pat);
  assign led       = (err_count == 16'h0) ? LED_OK : LED_BAD;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      err_count <= '0;
      first_err <= NO_ERR;
      pass      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      err_count <= err_count_nxt;
      first_err <= first_err_nxt;
      pass      <= pass_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    err_count_nxt = err_count;
    first_err_nxt = first_err;
    pass_nxt      = pass;

    mem_w_d       = 1'b0;
    addr_d        = '0;
    wdata_d       = '0;
    busy_d        = 1'b1;
    done_d        = 1'b0;

    unique case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_nxt     = WR;
          idx_nxt       = '0;
          err_count_nxt = '0;
          first_err_nxt = NO_ERR;
          pass_nxt      = 1'b0;
        end
      end

      WR: begin
        mem_w_d = 1'b1;
        addr_d  = word_addr;
        wdata_d = pat;
        if (last_idx) begin
          state_nxt = RD_ADDR;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 10'd1;
        end
      end

      RD_ADDR: begin
        addr_d    = word_addr;
        state_nxt = RD_CMP;
      end

      // The address is held so the one-cycle-latency read data lines up with
      // the index it is compared against.
      RD_CMP: begin
        addr_d = word_addr;
        if (mismatch) begin
          if (err_count != 16'hFFFF) begin
            err_count_nxt = err_count + 16'd1;
          end
          // err_count is still zero only on the first mismatch of the run.
          if (err_count == 16'h0) begin
            first_err_nxt = idx16;
          end
        end
        if (last_idx) begin
          state_nxt = REP_SEG;
        end else begin
          state_nxt = RD_ADDR;
          idx_nxt   = idx + 10'd1;
        end
      end

      REP_SEG: begin
        mem_w_d   = 1'b1;
        addr_d    = SEG_ADDR;
        wdata_d   = {err_count, first_err};
        state_nxt = REP_LED;
      end

      REP_LED: begin
        mem_w_d   = 1'b1;
        addr_d    = LED_ADDR;
        wdata_d   = {22'h0, led, 2'b00};
        pass_nxt  = (err_count == 16'h0);
        state_nxt = DONE;
      end

      // A start seen while done is high chains straight into the next run.
      DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (start) begin
          state_nxt     = WR;
          idx_nxt       = '0;
          err_count_nxt = '0;
          first_err_nxt = NO_ERR;
          pass_nxt      = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        busy_d    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.mem_w        = mem_w_d;
  assign bus.addr_bus     = addr_d;
  assign bus.Cpu_data2bus = wdata_d;
  assign busy             = busy_d;
  assign done             = done_d;

endmodule : bus_selftest_master
